// File: rtl/seq_ctrl.sv
// Instruction sequencer: fetch/decode/execute/write-back control with
// halt-request handling and a program counter / instruction register.
module seq_ctrl #(
   parameter int unsigned PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic            halt_req,
   input  logic [5:0]      instr_in,
   input  logic            mem_ack,
   output logic            mem_req,
   output logic [PC_W-1:0] pc,
   output logic [5:0]      ir,
   output logic            id_ce,
   output logic            exec_ce,
   output logic            wb_ce,
   output logic            busy,
   output logic            halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t state;
   state_t nxt;
   logic   halt_pend;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE, S_HALT: if (run && !halt_req) nxt = S_FETCH;
         S_FETCH:        if (mem_ack) nxt = S_DECODE;
         S_DECODE:       nxt = S_EXEC;
         S_EXEC:         nxt = S_WB;
         S_WB:           nxt = halt_pend ? S_HALT : S_FETCH;
         default:        nxt = S_IDLE;
      endcase
   end

   // Moore outputs are registered from the next state so they line up
   // exactly with the state register and clear asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= '0;
         ir        <= '0;
         halt_pend <= 1'b0;
         mem_req   <= 1'b0;
         id_ce     <= 1'b0;
         exec_ce   <= 1'b0;
         wb_ce     <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state   <= nxt;
         mem_req <= (nxt == S_FETCH);
         id_ce   <= (nxt inside {S_DECODE, S_EXEC, S_WB});
         exec_ce <= (nxt == S_EXEC);
         wb_ce   <= (nxt == S_WB);
         busy    <= !(nxt inside {S_IDLE, S_HALT});
         halted  <= (nxt == S_HALT);

         if (state == S_FETCH && mem_ack) begin
            ir <= instr_in;
            pc <= pc + PC_W'(1);
         end

         if (nxt == S_HALT)
            halt_pend <= 1'b0;
         else if (busy && halt_req)
            halt_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: scoreboard of fetched instruction/PC
// pairs plus per-scenario strobe and timing checks.
module tb_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic       halt_req;
   logic [5:0] instr_in;
   logic       mem_ack;
   logic       mem_req;
   logic [7:0] pc;
   logic [5:0] ir;
   logic       id_ce;
   logic       exec_ce;
   logic       wb_ce;
   logic       busy;
   logic       halted;

   typedef struct {
      logic [5:0] ir;
      logic [7:0] pc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model_pc;
   int         tests;
   int         fails;
   int         cyc;

   seq_ctrl #(.PC_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .halt_req (halt_req),
      .instr_in (instr_in),
      .mem_ack  (mem_ack),
      .mem_req  (mem_req),
      .pc       (pc),
      .ir       (ir),
      .id_ce    (id_ce),
      .exec_ce  (exec_ce),
      .wb_ce    (wb_ce),
      .busy     (busy),
      .halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // outputs packed as {mem_req, id_ce, exec_ce, wb_ce, busy, halted}
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; mem_ack = 1'b0; instr_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_pc = '0;
      sb.delete();
   endtask

   // Entered at the negedge of a FETCH cycle; returns at the negedge after WB.
   task automatic run_instr(input logic [5:0] instr, input int waits,
                            input bit halt_dec, input bit ack_noise);
      exp_t e;
      e.ir = '0; e.pc = '0;
      for (int w = 0; w < waits; w++) begin
         tests++;
         if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted} !== 6'b100010) begin
            fails++;
            $display("FAIL fetch_wait_outs: got %b exp 100010", {mem_req, id_ce, exec_ce, wb_ce, busy, halted});
         end
         tests++;
         if (pc !== model_pc) begin
            fails++;
            $display("FAIL fetch_wait_pc: got %h exp %h", pc, model_pc);
         end
         mem_ack = 1'b0; instr_in = 6'($urandom);
         @(negedge clk);
      end
      tests++;
      if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted} !== 6'b100010) begin
         fails++;
         $display("FAIL fetch_outs: got %b exp 100010", {mem_req, id_ce, exec_ce, wb_ce, busy, halted});
      end
      mem_ack = 1'b1; instr_in = instr;
      sb.push_back('{ir: instr, pc: model_pc + 8'd1});
      model_pc = model_pc + 8'd1;
      @(negedge clk);
      mem_ack = ack_noise; instr_in = ~instr; halt_req = halt_dec;
      tests++;
      if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted} !== 6'b010010) begin
         fails++;
         $display("FAIL decode_outs: got %b exp 010010", {mem_req, id_ce, exec_ce, wb_ce, busy, halted});
      end
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL sb_empty: got 0 entries exp 1");
      end else begin
         e = sb.pop_front();
         if (ir !== e.ir || pc !== e.pc) begin
            fails++;
            $display("FAIL decode_ir_pc: got ir=%b pc=%h exp ir=%b pc=%h", ir, pc, e.ir, e.pc);
         end
      end
      @(negedge clk);
      halt_req = 1'b0;
      tests++;
      if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted} !== 6'b011010) begin
         fails++;
         $display("FAIL exec_outs: got %b exp 011010", {mem_req, id_ce, exec_ce, wb_ce, busy, halted});
      end
      tests++;
      if (ir !== e.ir || pc !== e.pc) begin
         fails++;
         $display("FAIL exec_ir_pc: got ir=%b pc=%h exp ir=%b pc=%h", ir, pc, e.ir, e.pc);
      end
      @(negedge clk);
      tests++;
      if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted} !== 6'b010110) begin
         fails++;
         $display("FAIL wb_outs: got %b exp 010110", {mem_req, id_ce, exec_ce, wb_ce, busy, halted});
      end
      tests++;
      if (ir !== e.ir || pc !== e.pc) begin
         fails++;
         $display("FAIL wb_ir_pc: got ir=%b pc=%h exp ir=%b pc=%h", ir, pc, e.ir, e.pc);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b1; halt_req = 1'b0; mem_ack = 1'b1; instr_in = 6'h3F;
      #1;
      tests++;
      if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted, pc, ir} !== 20'h0) begin
         fails++;
         $display("FAIL reset_state: got outs=%b pc=%h ir=%b exp all zero",
                  {mem_req, id_ce, exec_ce, wb_ce, busy, halted}, pc, ir);
      end
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if ({mem_req, busy, halted} !== 3'b000 || pc !== 8'h00) begin
            fails++;
            $display("FAIL idle_hold: got req/busy/halted=%b pc=%h exp 000 pc=00", {mem_req, busy, halted}, pc);
         end
      end
   endtask

   task automatic test_basic();
      do_reset();
      run = 1'b1;
      @(negedge clk);
      run_instr(6'b100101, 0, 1'b0, 1'b0);
      tests++;
      if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted} !== 6'b100010 || pc !== 8'h01) begin
         fails++;
         $display("FAIL basic_refetch: got outs=%b pc=%h exp 100010 pc=01",
                  {mem_req, id_ce, exec_ce, wb_ce, busy, halted}, pc);
      end
   endtask

   task automatic test_ack_wait();
      int t0;
      t0 = cyc;
      run_instr(6'b010110, 3, 1'b0, 1'b0);
      tests++;
      if (cyc - t0 !== 7) begin
         fails++;
         $display("FAIL ack_wait_period: got %0d exp 7", cyc - t0);
      end
   endtask

   task automatic test_ack_outside_fetch();
      run_instr(6'b001101, 0, 1'b0, 1'b1);
      run_instr(6'b110010, 1, 1'b0, 1'b1);
   endtask

   task automatic test_halt();
      logic [5:0] last;
      last = 6'b111000;
      run = 1'b0;
      run_instr(last, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted} !== 6'b000001 || pc !== model_pc || ir !== last) begin
            fails++;
            $display("FAIL halt_state: got outs=%b pc=%h ir=%b exp 000001 pc=%h ir=%b",
                     {mem_req, id_ce, exec_ce, wb_ce, busy, halted}, pc, ir, model_pc, last);
         end
         @(negedge clk);
      end
      run = 1'b1;
      @(negedge clk);
      tests++;
      if ({mem_req, busy, halted} !== 3'b110 || pc !== model_pc) begin
         fails++;
         $display("FAIL halt_resume: got req/busy/halted=%b pc=%h exp 110 pc=%h", {mem_req, busy, halted}, pc, model_pc);
      end
      run_instr(6'b000111, 0, 1'b0, 1'b0);
      tests++;
      if ({mem_req, halted} !== 2'b10) begin
         fails++;
         $display("FAIL halt_pend_cleared: got req/halted=%b exp 10", {mem_req, halted});
      end
   endtask

   task automatic test_wrap();
      do_reset();
      run = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 255; i++) run_instr(6'($urandom), 0, 1'b0, 1'b0);
      tests++;
      if (pc !== 8'hFF) begin
         fails++;
         $display("FAIL wrap_pre: got %h exp ff", pc);
      end
      run_instr(6'b101010, 0, 1'b0, 1'b0);
      tests++;
      if (pc !== 8'h00 || {mem_req, busy, halted} !== 3'b110) begin
         fails++;
         $display("FAIL wrap_pc: got pc=%h req/busy/halted=%b exp pc=00 110", pc, {mem_req, busy, halted});
      end
      run_instr(6'b010101, 0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      do_reset();
      run = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1; instr_in = 6'h2A;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      tests++;
      if (exec_ce !== 1'b1) begin
         fails++;
         $display("FAIL areset_pre_exec: got %b exp 1", exec_ce);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({mem_req, id_ce, exec_ce, wb_ce, busy, halted, pc, ir} !== 20'h0) begin
         fails++;
         $display("FAIL areset_clear: got outs=%b pc=%h ir=%b exp all zero",
                  {mem_req, id_ce, exec_ce, wb_ce, busy, halted}, pc, ir);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (wb_ce !== 1'b0 || id_ce !== 1'b0) begin
            fails++;
            $display("FAIL areset_no_wb: got wb=%b id=%b exp 0 0", wb_ce, id_ce);
         end
      end
      run = 1'b0;
      rst_n = 1'b1;
      model_pc = '0;
      sb.delete();
      @(negedge clk);
      tests++;
      if ({mem_req, busy, wb_ce} !== 3'b000) begin
         fails++;
         $display("FAIL areset_idle: got req/busy/wb=%b exp 000", {mem_req, busy, wb_ce});
      end
   endtask

   task automatic test_run_halt_idle();
      do_reset();
      run = 1'b1; halt_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if ({mem_req, busy} !== 2'b00) begin
            fails++;
            $display("FAIL run_halt_idle: got req/busy=%b exp 00", {mem_req, busy});
         end
      end
      halt_req = 1'b0;
      @(negedge clk);
      run_instr(6'b011001, 0, 1'b0, 1'b0);
      tests++;
      if ({mem_req, halted} !== 2'b10) begin
         fails++;
         $display("FAIL idle_halt_no_pend: got req/halted=%b exp 10", {mem_req, halted});
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++)
         run_instr(6'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'($urandom));
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL b2b_sb_drain: got %0d entries exp 0", sb.size());
      end
   endtask

   initial begin
      tests = 0; fails = 0; model_pc = '0;
      rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; mem_ack = 1'b0; instr_in = '0;
      test_reset();
      test_basic();
      test_ack_wait();
      test_ack_outside_fetch();
      test_halt();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      test_run_halt_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
